stream_mux_n: RTL and testbench

//  N-channel, packet-aware stream multiplexer with valid/ready handshakes and a registered output.

---
 rtl/stream_mux_n_if.sv | 28 ++
 rtl/stream_mux_n.sv | 167 ++++++++++++++++
 tb/tb_stream_mux_n.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_n_if.sv
// Stream bundle between N input channels, the mux and one downstream sink.
// Latency: none (wiring only).
// Backpressure: s_ready per channel from the mux; m_ready from the downstream sink.
// Ports: s_data/s_valid/s_last in, s_ready back; m_data/m_valid/m_last out, m_ready back.
// master = environment side (sources and sink); slave = the mux.
interface stream_mux_n_if #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 4
);
    logic [N_CH*WIDTH-1:0] s_data;
    logic [N_CH-1:0]       s_valid;
    logic [N_CH-1:0]       s_last;
    logic [N_CH-1:0]       s_ready;
    logic [WIDTH-1:0]      m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel packet-aware stream mux; round-robin or external select, packets never interleaved.
// Latency: one grant cycle per packet, then a beat accepted at edge t is on m_* after edge t.
// Backpressure: only the locked channel sees s_ready, equal to !m_valid | m_ready.
// Ports: clk, rst_n (async, active low); bus (stream bundle, slave side);
//        sel (requested channel, external mode only); busy (channel locked); cur_ch (granted channel).
module stream_mux_n #(
    parameter int WIDTH   = 32,
    parameter int N_CH    = 4,
    parameter int SEL_W   = $clog2(N_CH),
    parameter int RR_MODE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_mux_n_if.slave      bus,
    input  logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [SEL_W-1:0]   cur_ch
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_cur_ch, w_cur_ch_nxt;
    logic [SEL_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic               r_busy, w_busy_nxt;
    logic [WIDTH-1:0]   r_m_data, w_m_data_nxt;
    logic               r_m_valid, w_m_valid_nxt;
    logic               r_m_last, w_m_last_nxt;

    logic [SEL_W-1:0]   w_start;
    logic [N_CH-1:0]    w_rot;
    int                 w_pos;
    logic               w_grant_vld;
    logic [SEL_W-1:0]   w_grant_ch;

    logic               w_cur_vld;
    logic [WIDTH-1:0]   w_cur_dat;
    logic               w_cur_last;
    logic               w_take;
    logic               w_accept;
    logic [N_CH-1:0]    w_s_ready;

    // Round-robin scan starts one past the last packet's channel; rr_ptr=N_CH-1 wraps to ch0.
    assign w_start = (r_rr_ptr == SEL_W'(N_CH - 1)) ? '0 : r_rr_ptr + 1'b1;
    // Rotate valids so bit k is channel (w_start + k) mod N_CH; lowest set bit wins.
    assign w_rot   = N_CH'({bus.s_valid, bus.s_valid} >> w_start);

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_pos       = 0;
        if (RR_MODE != 0) begin
            // Descending loop so the smallest offset is the last one written.
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (w_rot[k]) begin
                    w_grant_vld = 1'b1;
                    w_pos       = int'(w_start) + k;
                end
            end
            if (w_pos >= N_CH) begin
                w_pos = w_pos - N_CH;
            end
            w_grant_ch = SEL_W'(w_pos);
        end else begin
            // An out-of-range sel matches no channel, so nothing is granted.
            for (int i = 0; i < N_CH; i++) begin
                if (sel == SEL_W'(i) && bus.s_valid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant_ch  = sel;
                end
            end
        end
    end

    // Locked-channel view, built with constant indices only.
    always_comb begin
        w_cur_vld  = 1'b0;
        w_cur_dat  = '0;
        w_cur_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_cur_ch == SEL_W'(i)) begin
                w_cur_vld  = bus.s_valid[i];
                w_cur_dat  = bus.s_data[i*WIDTH +: WIDTH];
                w_cur_last = bus.s_last[i];
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign w_take   = !r_m_valid || bus.m_ready;
    assign w_accept = (r_state == LOCK) && w_cur_vld && w_take;

    always_comb begin
        w_s_ready = '0;
        if (r_state == LOCK) begin
            for (int i = 0; i < N_CH; i++) begin
                w_s_ready[i] = (r_cur_ch == SEL_W'(i)) && w_take;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_ch_nxt  = r_cur_ch;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_busy_nxt    = r_busy;
        w_m_data_nxt  = r_m_data;
        w_m_valid_nxt = r_m_valid;
        w_m_last_nxt  = r_m_last;

        // Output register: load on accept, otherwise drain when the sink takes the beat.
        if (w_accept) begin
            w_m_data_nxt  = w_cur_dat;
            w_m_last_nxt  = w_cur_last;
            w_m_valid_nxt = 1'b1;
        end else if (bus.m_ready) begin
            w_m_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_cur_ch_nxt = w_grant_ch;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = LOCK;
                end
            end
            LOCK: begin
                if (w_accept && w_cur_last) begin
                    w_rr_ptr_nxt = r_cur_ch;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cur_ch  <= '0;
            r_rr_ptr  <= SEL_W'(N_CH - 1);
            r_busy    <= 1'b0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_ch  <= w_cur_ch_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_busy    <= w_busy_nxt;
            r_m_data  <= w_m_data_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_m_last  <= w_m_last_nxt;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_data  = r_m_data;
    assign bus.m_valid = r_m_valid;
    assign bus.m_last  = r_m_last;
    assign busy        = r_busy;
    assign cur_ch      = r_cur_ch;
endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: a round-robin instance and an external-select instance.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: m_ready driven per scenario.
module tb_stream_mux_n;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel_a;
    logic       busy_a;
    logic [1:0] cur_a;
    logic [2:0] sel_b;
    logic       busy_b;
    logic [2:0] cur_b;
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    stream_mux_n_if #(.WIDTH(32), .N_CH(4)) bus_a ();
    stream_mux_n_if #(.WIDTH(32), .N_CH(4)) bus_b ();

    stream_mux_n #(.WIDTH(32), .N_CH(4), .RR_MODE(1)) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_a),
        .sel    (sel_a),
        .busy   (busy_a),
        .cur_ch (cur_a)
    );

    // Three-bit sel so that an out-of-range channel number can be requested.
    stream_mux_n #(.WIDTH(32), .N_CH(4), .SEL_W(3), .RR_MODE(0)) u_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_b),
        .sel    (sel_b),
        .busy   (busy_b),
        .cur_ch (cur_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input int ch, input logic [31:0] d, input logic l);
        bus_a.s_data[ch*32 +: 32] = d;
        bus_a.s_last[ch]          = l;
    endtask

    task automatic put_b(input int ch, input logic [31:0] d, input logic l);
        bus_b.s_data[ch*32 +: 32] = d;
        bus_b.s_last[ch]          = l;
    endtask

    initial begin
        rst_n         = 1'b0;
        sel_a         = 2'd0;
        sel_b         = 3'd0;
        bus_a.s_data  = '0;
        bus_a.s_valid = '0;
        bus_a.s_last  = '0;
        bus_a.m_ready = 1'b1;
        bus_b.s_data  = '0;
        bus_b.s_valid = '0;
        bus_b.s_last  = '0;
        bus_b.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_valid", 32'(bus_a.m_valid), 32'd0);
        chk("rst m_data",  bus_a.m_data,       32'd0);
        chk("rst m_last",  32'(bus_a.m_last),  32'd0);
        chk("rst busy",    32'(busy_a),        32'd0);
        chk("rst cur_ch",  32'(cur_a),         32'd0);
        chk("rst s_ready", 32'(bus_a.s_ready), 32'd0);
        rst_n = 1'b1;

        // ch2 three-beat packet, sink always ready
        put_a(2, 32'hA0, 1'b0);
        bus_a.s_valid = 4'b0100;
        #1 chk("t1 idle s_ready", 32'(bus_a.s_ready), 32'd0);
        cyc();
        chk("t1 grant busy",    32'(busy_a),        32'd1);
        chk("t1 grant cur_ch",  32'(cur_a),         32'd2);
        chk("t1 grant m_valid", 32'(bus_a.m_valid), 32'd0);
        chk("t1 lock s_ready",  32'(bus_a.s_ready), 32'b0100);
        cyc();
        chk("t1 b0 m_valid", 32'(bus_a.m_valid), 32'd1);
        chk("t1 b0 m_data",  bus_a.m_data,       32'hA0);
        chk("t1 b0 m_last",  32'(bus_a.m_last),  32'd0);
        put_a(2, 32'hA1, 1'b0);
        cyc();
        chk("t1 b1 m_data", bus_a.m_data, 32'hA1);
        put_a(2, 32'hA2, 1'b1);
        cyc();
        chk("t1 b2 m_data", bus_a.m_data,       32'hA2);
        chk("t1 b2 m_last", 32'(bus_a.m_last),  32'd1);
        chk("t1 b2 busy",   32'(busy_a),        32'd0);
        bus_a.s_valid = 4'b0000;
        #1 chk("t1 end s_ready", 32'(bus_a.s_ready), 32'd0);
        cyc();
        chk("t1 drain m_valid", 32'(bus_a.m_valid), 32'd0);

        // one-beat ch0 packet leaves rr_ptr=0
        put_a(0, 32'hB0, 1'b1);
        bus_a.s_valid = 4'b0001;
        cyc();
        chk("t2 b0 cur_ch", 32'(cur_a), 32'd0);
        cyc();
        chk("t2 single m_data", bus_a.m_data,      32'hB0);
        chk("t2 single m_last", 32'(bus_a.m_last), 32'd1);
        chk("t2 single busy",   32'(busy_a),       32'd0);
        // ch0 and ch3 compete; scan from ch1 picks ch3
        put_a(0, 32'hC0, 1'b0);
        put_a(3, 32'hD0, 1'b0);
        bus_a.s_valid = 4'b1001;
        #1 chk("t2 idle s_ready", 32'(bus_a.s_ready), 32'd0);
        cyc();
        chk("t2 grant3 cur_ch",  32'(cur_a),         32'd3);
        chk("t2 bubble m_valid", 32'(bus_a.m_valid), 32'd0);
        chk("t2 ch3 s_ready",    32'(bus_a.s_ready), 32'b1000);
        cyc();
        chk("t2 d0 m_data", bus_a.m_data, 32'hD0);
        put_a(3, 32'hD1, 1'b1);
        cyc();
        chk("t2 d1 m_data", bus_a.m_data,      32'hD1);
        chk("t2 d1 m_last", 32'(bus_a.m_last), 32'd1);
        bus_a.s_valid = 4'b0001;
        cyc();
        chk("t2 grant0 cur_ch",   32'(cur_a),         32'd0);
        chk("t2 bubble2 m_valid", 32'(bus_a.m_valid), 32'd0);
        cyc();
        chk("t2 c0 m_data", bus_a.m_data,      32'hC0);
        chk("t2 c0 m_last", 32'(bus_a.m_last), 32'd0);
        put_a(0, 32'hC1, 1'b1);
        cyc();
        chk("t2 c1 m_data", bus_a.m_data, 32'hC1);
        chk("t2 c1 busy",   32'(busy_a),  32'd0);
        bus_a.s_valid = 4'b0000;

        // ch1 packet with a 5-cycle sink stall after its first beat
        put_a(1, 32'hE0, 1'b0);
        bus_a.s_valid = 4'b0010;
        cyc();
        chk("t3 grant cur_ch", 32'(cur_a), 32'd1);
        cyc();
        chk("t3 e0 m_data", bus_a.m_data, 32'hE0);
        put_a(1, 32'hE1, 1'b0);
        bus_a.m_ready = 1'b0;
        #1 chk("t3 stall s_ready", 32'(bus_a.s_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3 hold m_valid", 32'(bus_a.m_valid), 32'd1);
            chk("t3 hold m_data",  bus_a.m_data,       32'hE0);
            chk("t3 hold s_ready", 32'(bus_a.s_ready), 32'd0);
        end
        bus_a.m_ready = 1'b1;
        #1 chk("t3 resume s_ready", 32'(bus_a.s_ready), 32'b0010);
        cyc();
        chk("t3 e1 m_data",  bus_a.m_data,       32'hE1);
        chk("t3 e1 m_valid", 32'(bus_a.m_valid), 32'd1);
        put_a(1, 32'hE2, 1'b1);
        cyc();
        chk("t3 e2 m_data", bus_a.m_data,      32'hE2);
        chk("t3 e2 m_last", 32'(bus_a.m_last), 32'd1);
        bus_a.s_valid = 4'b0000;
        cyc();
        chk("t3 drain m_valid", 32'(bus_a.m_valid), 32'd0);

        // external select: sel moves to 3 while ch1 is locked
        sel_b = 3'd1;
        put_b(1, 32'hF0, 1'b0);
        put_b(3, 32'h60, 1'b1);
        bus_b.s_valid = 4'b1010;
        #1 chk("t4 idle s_ready", 32'(bus_b.s_ready), 32'd0);
        cyc();
        chk("t4 grant cur_ch", 32'(cur_b), 32'd1);
        sel_b = 3'd3;
        #1 chk("t4 lock s_ready", 32'(bus_b.s_ready), 32'b0010);
        cyc();
        chk("t4 f0 m_data", bus_b.m_data, 32'hF0);
        put_b(1, 32'hF1, 1'b1);
        cyc();
        chk("t4 f1 m_data", bus_b.m_data,      32'hF1);
        chk("t4 f1 m_last", 32'(bus_b.m_last), 32'd1);
        chk("t4 f1 busy",   32'(busy_b),       32'd0);
        bus_b.s_valid = 4'b1000;
        cyc();
        chk("t4 grant3 cur_ch", 32'(cur_b),         32'd3);
        chk("t4 bubble m_valid", 32'(bus_b.m_valid), 32'd0);
        cyc();
        chk("t4 g0 m_data", bus_b.m_data,      32'h60);
        chk("t4 g0 m_last", 32'(bus_b.m_last), 32'd1);
        bus_b.s_valid = 4'b0000;
        cyc();
        chk("t4 drain m_valid", 32'(bus_b.m_valid), 32'd0);

        // out-of-range sel never grants
        sel_b = 3'd5;
        for (int i = 0; i < 4; i++) put_b(i, 32'h70 + 32'(i), 1'b1);
        bus_b.s_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5 busy",    32'(busy_b),        32'd0);
            chk("t5 s_ready", 32'(bus_b.s_ready), 32'd0);
            chk("t5 m_valid", 32'(bus_b.m_valid), 32'd0);
        end
        bus_b.s_valid = 4'b0000;

        // reset mid-packet on the round-robin instance (rr_ptr=1 beforehand)
        put_a(2, 32'h80, 1'b0);
        bus_a.s_valid = 4'b0100;
        cyc();
        chk("t6 grant cur_ch", 32'(cur_a), 32'd2);
        cyc();
        chk("t6 h0 m_data", bus_a.m_data, 32'h80);
        rst_n = 1'b0;
        #1;
        chk("t6 rst m_valid", 32'(bus_a.m_valid), 32'd0);
        chk("t6 rst busy",    32'(busy_a),        32'd0);
        chk("t6 rst cur_ch",  32'(cur_a),         32'd0);
        chk("t6 rst s_ready", 32'(bus_a.s_ready), 32'd0);
        bus_a.s_valid = 4'b1111;
        #2 rst_n = 1'b1;
        cyc();
        chk("t6 post cur_ch", 32'(cur_a),  32'd0);
        chk("t6 post busy",   32'(busy_a), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
